// File: rtl/result_wb_arbiter_if.sv
// Result write-back bus: three producer request channels plus the
// register-file write port and the contention counter.
// slave  : arbiter side
// master : producer / register-file side
interface result_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [2:0]        src_valid;
  logic [2:0]        src_ready;
  logic [DATA_W-1:0] src0_data;
  logic [DATA_W-1:0] src1_data;
  logic [DATA_W-1:0] src2_data;
  logic [ADDR_W-1:0] src0_addr;
  logic [ADDR_W-1:0] src1_addr;
  logic [ADDR_W-1:0] src2_addr;
  logic              wb_stall;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  src_valid, src0_data, src1_data, src2_data,
           src0_addr, src1_addr, src2_addr, wb_stall,
    output src_ready, wb_en, wb_addr, wb_data, conflict_cnt
  );

  modport master (
    output src_valid, src0_data, src1_data, src2_data,
           src0_addr, src1_addr, src2_addr, wb_stall,
    input  src_ready, wb_en, wb_addr, wb_data, conflict_cnt
  );
endinterface

// File: rtl/result_wb_arbiter.sv
// Write-back arbiter: picks one of ALU / load / multiplier results per
// cycle, registers it for the register-file write port, suppresses r0
// writes and counts contention cycles.
// Optional macro WB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it, fixed priority src0 > src1 > src2 is used.
module result_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  result_wb_arbiter_if.slave bus
);

  logic              can_accept;
  logic              any_grant;
  logic [1:0]        grant_idx;
  logic [2:0]        grant;
  logic              accept;
  logic              multi_valid;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;

  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [CNT_W-1:0]  cnt_q;

  // The output register is free when empty or when it retires this cycle.
  assign can_accept = !bus.wb_stall || !wb_en_q;

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] last_grant;
  logic [1:0] ord0, ord1, ord2;

  // Search order starts just after the most recently granted source.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (last_grant)
      2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
  end

  // Pick the first valid source in rotated order.
  always_comb begin
    any_grant = 1'b1;
    grant_idx = ord0;
    if (bus.src_valid[ord0])      grant_idx = ord0;
    else if (bus.src_valid[ord1]) grant_idx = ord1;
    else if (bus.src_valid[ord2]) grant_idx = ord2;
    else                          any_grant = 1'b0;
  end

  // Pointer moves only on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 2'd2;
    else if (accept) last_grant <= grant_idx;
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    any_grant = 1'b1;
    grant_idx = 2'd0;
    if (bus.src_valid[0])      grant_idx = 2'd0;
    else if (bus.src_valid[1]) grant_idx = 2'd1;
    else if (bus.src_valid[2]) grant_idx = 2'd2;
    else                       any_grant = 1'b0;
  end
`endif

  // One-hot ready, gated by reset so nothing is offered while held in reset.
  always_comb begin
    grant = 3'b000;
    if (any_grant) grant[grant_idx] = 1'b1;
  end

  assign accept        = any_grant && can_accept && rst_n;
  assign bus.src_ready = accept ? grant : 3'b000;

  // Data/address mux for the granted source.
  always_comb begin
    sel_data = bus.src0_data;
    sel_addr = bus.src0_addr;
    case (grant_idx)
      2'd1: begin sel_data = bus.src1_data; sel_addr = bus.src1_addr; end
      2'd2: begin sel_data = bus.src2_data; sel_addr = bus.src2_addr; end
      default: begin sel_data = bus.src0_data; sel_addr = bus.src0_addr; end
    endcase
  end

  assign multi_valid = (bus.src_valid[0] & bus.src_valid[1]) |
                       (bus.src_valid[0] & bus.src_valid[2]) |
                       (bus.src_valid[1] & bus.src_valid[2]);

  // Output register: capture on accept, clear strobe when idle, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (can_accept) begin
      if (accept) begin
        wb_en_q   <= (sel_addr != '0);
        wb_addr_q <= sel_addr;
        wb_data_q <= sel_data;
      end else begin
        wb_en_q   <= 1'b0;
      end
    end
  end

  // Saturating contention counter, independent of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt_q <= '0;
    else if (multi_valid && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign bus.wb_en        = wb_en_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_result_wb_arbiter.sv
// Bench for result_wb_arbiter: reference model decides grants from the
// arbitration rules; expected writes go to a queue and a separate monitor
// compares every new entry presented on the write port.
module tb_result_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  result_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))     bus4 ();

  assign bus4.src_valid = bus.src_valid;
  assign bus4.src0_data = bus.src0_data;
  assign bus4.src1_data = bus.src1_data;
  assign bus4.src2_data = bus.src2_data;
  assign bus4.src0_addr = bus.src0_addr;
  assign bus4.src1_addr = bus.src1_addr;
  assign bus4.src2_addr = bus.src2_addr;
  assign bus4.wb_stall  = bus.wb_stall;

  result_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  result_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct { logic [4:0] a; logic [31:0] d; } wb_t;
  wb_t q[$];

  int errors = 0;
  int checks = 0;

  bit          pend [3];
  logic [31:0] pdata[3];
  logic [4:0]  paddr[3];
  bit          stall;
  int          lg;
  bit          m_full;
  int          m_cnt, m_cnt4;
  logic [2:0]  obs_ready;
  bit          prev_held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] v, input int last);
    int idx;
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < 3; k++) begin
      idx = k;
      if (v[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic drive();
    bus.src_valid = {pend[2], pend[1], pend[0]};
    bus.src0_data = pdata[0]; bus.src0_addr = paddr[0];
    bus.src1_data = pdata[1]; bus.src1_addr = paddr[1];
    bus.src2_data = pdata[2]; bus.src2_addr = paddr[2];
    bus.wb_stall  = stall;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    pend[i] = 1'b1; paddr[i] = a; pdata[i] = d;
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_cnt = 0; m_cnt4 = 0; lg = 2;
    q.delete();
  endtask

  // One clock cycle: drive, predict, compare, advance the model.
  task automatic do_cycle(input bit rnd);
    logic [2:0] v;
    logic [2:0] exp_ready;
    bit can;
    int g;
    @(negedge clk);
    if (rnd) begin
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      stall = ($urandom_range(0, 3) == 0);
    end
    drive();
    #1;
    v = {pend[2], pend[1], pend[0]};
    can = !stall || !m_full;
    g = can ? pick(v, lg) : -1;
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("src_ready", bus.src_ready, exp_ready);
    chk("wb_en_state", bus.wb_en, m_full);
    chk("conflict_cnt", bus.conflict_cnt, m_cnt);
    chk("conflict_cnt4", bus4.conflict_cnt, m_cnt4);
    obs_ready = bus.src_ready;
    if ($countones(v) >= 2) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (can) begin
      m_full = (g >= 0) && (paddr[g] != 5'd0);
      if (g >= 0) begin
        if (paddr[g] != 5'd0) q.push_back('{paddr[g], pdata[g]});
        pend[g] = 1'b0;
        lg = g;
      end
    end
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    stall = 1'b0;
    drive();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every newly presented write entry must match the queue head.
  initial begin
    wb_t e;
    prev_held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_held = 1'b0;
      end else begin
        if (bus.wb_en && !prev_held) begin
          if (q.size() == 0) begin
            chk("wb_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("wb_addr", bus.wb_addr, e.a);
            chk("wb_data", bus.wb_data, e.d);
          end
        end
        prev_held = bus.wb_en && bus.wb_stall;
      end
    end
  end

  int exp_ord[6];
  int guard;

  initial begin
    for (int i = 0; i < 3; i++) set_req(i, 5'd5, 32'hA5A5_0000 + 32'(i));
    stall = 1'b0;
    drive();
    model_reset();
    #12;
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_cnt", bus.conflict_cnt, 0);
    chk("rst_ready", bus.src_ready, 3'b000);

    // Single source, negative data.
    reset_all();
    set_req(1, 5'd7, 32'hFFFF_FFFB);
    do_cycle(0);
    chk("single_ready", obs_ready, 3'b010);
    do_cycle(0);
    chk("single_wb_en", bus.wb_en, 1);
    chk("single_wb_addr", bus.wb_addr, 7);
    chk("single_wb_data", bus.wb_data, 32'hFFFF_FFFB);
    do_cycle(0);
    chk("single_wb_en_off", bus.wb_en, 0);

    // r0 write is consumed silently.
    set_req(0, 5'd0, 32'h1234);
    do_cycle(0);
    chk("r0_ready", obs_ready, 3'b001);
    do_cycle(0);
    chk("r0_wb_en", bus.wb_en, 0);

    // Contention: all three valid for 6 cycles.
    reset_all();
`ifdef WB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 2, 0, 1, 2};
`else
    exp_ord = '{0, 0, 0, 0, 0, 0};
`endif
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++)
        if (!pend[i]) set_req(i, 5'(8 + 3 * c + i), $urandom);
      do_cycle(0);
      chk("contention_grant", obs_ready, 3'(1 << exp_ord[c]));
    end
    @(posedge clk);
    #1 chk("contention_cnt", bus.conflict_cnt, 6);

    // Stall holds the output entry.
    reset_all();
    set_req(2, 5'd3, 32'h7FFF_FFFF);
    do_cycle(0);
    set_req(0, 5'd9, 32'h55);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      do_cycle(0);
      chk("stall_ready", obs_ready, 3'b000);
      chk("stall_wb_en", bus.wb_en, 1);
      chk("stall_wb_addr", bus.wb_addr, 3);
      chk("stall_wb_data", bus.wb_data, 32'h7FFF_FFFF);
    end
    stall = 1'b0;
    do_cycle(0);
    chk("stall_release_ready", obs_ready, 3'b001);
    do_cycle(0);

    // Reset while an entry is held and all sources request.
    reset_all();
    for (int i = 0; i < 3; i++) set_req(i, 5'(20 + i), 32'hC0DE_0000 + 32'(i));
    do_cycle(0);
    do_cycle(0);
    @(posedge clk);
    #2;
    chk("mid_pre_wb_en", bus.wb_en, 1);
    for (int i = 0; i < 3; i++)
      if (!pend[i]) set_req(i, 5'(20 + i), 32'hC0DE_0000 + 32'(i));
    drive();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_wb_en", bus.wb_en, 0);
    chk("mid_ready", bus.src_ready, 3'b000);
    chk("mid_cnt", bus.conflict_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_cycle(0);
    chk("mid_first_grant", obs_ready, 3'b001);

    // Saturation: two valids held for 20 cycles.
    reset_all();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) set_req(i, 5'(1 + i), $urandom);
      do_cycle(0);
    end
    @(posedge clk);
    #1;
    chk("sat_cnt4", bus4.conflict_cnt, 15);
    chk("sat_cnt16", bus.conflict_cnt, 20);

    // Randomized traffic with random stalls and r0 writes.
    reset_all();
    for (int c = 0; c < 3000; c++) do_cycle(1);
    stall = 1'b0;
    guard = 0;
    while ((pend[0] || pend[1] || pend[2] || m_full) && guard < 20) begin
      do_cycle(0);
      guard++;
    end
    chk("drain_timeout", (guard < 20) ? 1 : 0, 1);
    #5;
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
